// File: rtl/and_gate.sv
// and_gate: registered N-bit bitwise AND with sign and zero status flags
// Ports: clk (rising edge), rst (sync active-high), A_num/B_num (N-bit operands),
//        in_valid (operands valid), result (A_num & B_num, 1-cycle latency),
//        sign (result MSB), zero (result == 0), out_valid (one-cycle pulse per accepted pair)
module and_gate #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] A_num,
    input  logic [N-1:0] B_num,
    input  logic         in_valid,
    output logic [N-1:0] result,
    output logic         sign,
    output logic         zero,
    output logic         out_valid
);
    logic [N-1:0] w_and;
    logic [N-1:0] r_result;
    logic         r_sign;
    logic         r_zero;
    logic         r_out_valid;
    assign w_and = A_num & B_num;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_result    <= '0;
            r_sign      <= 1'b0;
            r_zero      <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= in_valid;
            // Flags come from the same combinational value as the result, so all three stay coherent.
            if (in_valid) begin
                r_result <= w_and;
                r_sign   <= w_and[N-1];
                r_zero   <= (w_and == '0);
            end
        end
    end
    assign result    = r_result;
    assign sign      = r_sign;
    assign zero      = r_zero;
    assign out_valid = r_out_valid;
endmodule

// File: tb/tb_and_gate.sv
// tb_and_gate: scoreboard bench for and_gate (N=4), directed vectors plus random back-to-back pairs
module tb_and_gate;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] A_num = '0;
    logic [3:0] B_num = '0;
    logic       in_valid = 1'b0;
    logic [3:0] result;
    logic       sign;
    logic       zero;
    logic       out_valid;
    logic [5:0] q[$];
    int         n = 0;
    int         errs = 0;

    and_gate #(.N(4)) dut (
        .clk(clk), .rst(rst), .A_num(A_num), .B_num(B_num), .in_valid(in_valid),
        .result(result), .sign(sign), .zero(zero), .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [6:0] got, input logic [6:0] exp);
        n++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got {result,sign,zero,out_valid}=%b expected %b", name, got, exp);
        end
    endtask

    task automatic apply(input logic [3:0] a, input logic [3:0] b, input logic v, input logic r,
                         input logic [3:0] er, input logic es, input logic ez);
        @(negedge clk);
        A_num = a;
        B_num = b;
        in_valid = v;
        rst = r;
        if (v && !r) q.push_back({er, es, ez});
    endtask

    task automatic apply_rand(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] e;
        e = a & b;
        apply(a, b, 1'b1, 1'b0, e, e[3], e == 4'h0);
    endtask

    // monitor: every out_valid pulse must match the oldest queued expectation
    initial begin
        logic [5:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                if (q.size() == 0) chk("unexpected_out_valid", {result, sign, zero, 1'b1}, 7'b0);
                else begin
                    e = q.pop_front();
                    chk("scoreboard", {result, sign, zero, out_valid}, {e, 1'b1});
                end
            end
        end
    end

    initial begin
        apply($urandom_range(0, 15), $urandom_range(0, 15), 1'b1, 1'b1, 4'h0, 1'b0, 1'b0);
        apply($urandom_range(0, 15), $urandom_range(0, 15), 1'b0, 1'b1, 4'h0, 1'b0, 1'b0);
        @(posedge clk); #2;
        chk("reset_state", {result, sign, zero, out_valid}, {4'h0, 1'b0, 1'b1, 1'b0});
        apply(4'h0, 4'h0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b1);
        apply(4'h0, 4'h1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b1);
        apply(4'h1, 4'h0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b1);
        apply(4'h1, 4'h1, 1'b1, 1'b0, 4'h1, 1'b0, 1'b0);
        apply(4'hF, 4'h9, 1'b1, 1'b0, 4'h9, 1'b1, 1'b0);
        apply(4'hA, 4'h5, 1'b1, 1'b0, 4'h0, 1'b0, 1'b1);
        apply(4'hC, 4'hE, 1'b1, 1'b0, 4'hC, 1'b1, 1'b0);
        apply(4'h3, 4'h5, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
        @(posedge clk); #2;
        chk("hold", {result, sign, zero, out_valid}, {4'hC, 1'b1, 1'b0, 1'b0});
        apply(4'h6, 4'h7, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
        @(posedge clk); #2;
        chk("hold_2", {result, sign, zero, out_valid}, {4'hC, 1'b1, 1'b0, 1'b0});
        apply(4'hF, 4'hF, 1'b1, 1'b1, 4'h0, 1'b0, 1'b0);
        @(posedge clk); #2;
        chk("reset_priority", {result, sign, zero, out_valid}, {4'h0, 1'b0, 1'b1, 1'b0});
        apply(4'h7, 4'h3, 1'b1, 1'b0, 4'h3, 1'b0, 1'b0);
        apply(4'hE, 4'hB, 1'b1, 1'b0, 4'hA, 1'b1, 1'b0);
        for (int i = 0; i < 1000; i++) apply_rand(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        apply(4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #2;
        chk("queue_drained", {q.size() == 0, 6'b0}, {1'b1, 6'b0});
        $display("== %0d vectors applied, %0d miscompares ==", n, errs);
        $finish;
    end
endmodule
